mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester (IF, read-only)
// and a load/store requester (LS). Only one transaction is in flight at a time.
// In IDLE one requester is granted. A tie goes to the requester that was not
// granted last. The command is registered onto the memory port (ISSUE). For a
// load the block then waits for mem_rvalid (RESP), with a timeout that returns
// ERR_DATA and sets a sticky err flag.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   if_req/if_addr            fetch request; if_gnt accept, if_rvalid/if_rdata response
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_wstrb         load/store request; ls_gnt accept, ls_rvalid/ls_rdata response
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb       registered memory command
//   mem_ready                 memory accepts the command while mem_req=1
//   mem_rvalid/mem_rdata      memory read response
//   busy                      state is not IDLE
//   err                       sticky read-timeout flag
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Owner / last-granted encoding: 0 = IF, 1 = LS.
  state_e             state_q,     state_d;
  logic               last_ls_q,   last_ls_d;
  logic               owner_q,     owner_d;
  logic               mem_req_q,   mem_req_d;
  logic               mem_we_q,    mem_we_d;
  logic [31:0]        mem_addr_q,  mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               err_q,       err_d;
  logic               if_rvalid_q, if_rvalid_d;
  logic               ls_rvalid_q, ls_rvalid_d;
  logic [31:0]        if_rdata_q,  if_rdata_d;
  logic [31:0]        ls_rdata_q,  ls_rdata_d;

  logic               if_gnt_c, ls_gnt_c, win_ls;
  logic               rsp_valid;
  logic [31:0]        rsp_data;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt_c    = 1'b0;
    ls_gnt_c    = 1'b0;
    win_ls      = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;

    unique case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          // LS wins when it is alone, or on a tie when IF was granted last.
          win_ls      = ls_req && (!if_req || !last_ls_q);
          if_gnt_c    = !win_ls;
          ls_gnt_c    = win_ls;
          last_ls_d   = win_ls;
          owner_d     = win_ls;
          mem_req_d   = 1'b1;
          mem_we_d    = win_ls && ls_we;
          mem_addr_d  = win_ls ? ls_addr  : if_addr;
          mem_wdata_d = win_ls ? ls_wdata : '0;
          mem_wstrb_d = win_ls ? ls_wstrb : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_we_q) begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_rdata;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This idle cycle brings the count to TIMEOUT: abort the read.
          rsp_valid = 1'b1;
          rsp_data  = ERR_DATA;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Response goes only to the owner; the other side keeps its last rdata.
    if (rsp_valid) begin
      if (owner_q) begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = rsp_data;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_ls_q   <= 1'b1;  // IF wins the first tie
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so the order of these statements does not matter.
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_c;
  assign ls_gnt    = ls_gnt_c;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A grant monitor pushes the
// expected response (owner and rdata) into a scoreboard queue; a response
// monitor pops and compares it when either rvalid pulses. A small memory
// model answers accepted reads one cycle later unless responses are disabled.
// Directed sections check arbitration, latency, backpressure, timeout, reset
// and stray responses. Inputs change 1 ns after the rising edge and outputs
// are sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam int unsigned TO       = 64;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        owner;  // 0 = IF, 1 = LS
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  // Memory model controls.
  logic        resp_en;
  logic        stray;
  logic [31:0] stray_data;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rv_count = 0;

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR_WORD)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wstrb  (ls_wstrb),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h4) ? 32'h0050_0113 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) begin
        who = ls_gnt ? 1 : 0;
        cyc = i;
        break;
      end
    end
    if (who < 0) check("gnt_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    step();
  endtask

  // Memory model: a read accepted in cycle k is answered in cycle k+1.
  // A stray pulse requested in cycle k also appears in cycle k+1.
  initial begin
    logic        acc;
    logic        st;
    logic [31:0] acc_addr;
    logic [31:0] st_data;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc      = rst && mem_req && mem_ready && !mem_we && resp_en;
      acc_addr = mem_addr;
      st       = stray;
      st_data  = stray_data;
      @(posedge clk);
      #1;
      mem_rvalid = acc || st;
      if (acc)     mem_rdata = mem_word(acc_addr);
      else if (st) mem_rdata = st_data;
    end
  end

  // Grant monitor pushes expectations; response monitor pops and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (if_gnt && ls_gnt) check("gnt_both", 32'd1, 32'd0);
        else if (if_gnt) sb.push_back('{owner: 1'b0, data: mem_word(if_addr)});
        else if (ls_gnt)
          sb.push_back('{owner: 1'b1,
                         data: ls_we ? 32'h0 : (resp_en ? mem_word(ls_addr) : ERR_WORD)});
        if (if_rvalid && ls_rvalid) check("rv_both", 32'd1, 32'd0);
        else if (if_rvalid || ls_rvalid) begin
          rv_count++;
          if (sb.size() == 0) check("rv_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check("rv_owner", 32'(ls_rvalid), 32'(e.owner));
            check("rv_rdata", ls_rvalid ? ls_rdata : if_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int who;
    int cyc;
    int rvc;
    rst        = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    ls_req     = 1'b0;
    ls_we      = 1'b0;
    ls_addr    = '0;
    ls_wdata   = '0;
    ls_wstrb   = '0;
    mem_ready  = 1'b1;
    resp_en    = 1'b1;
    stray      = 1'b0;
    stray_data = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_rvalid",    32'({if_rvalid, ls_rvalid, if_gnt, ls_gnt}), 32'd0);
    check("rst_if_rdata",  if_rdata,       32'd0);
    check("rst_ls_rdata",  ls_rdata,       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err",       32'(err),       32'd0);

    // Tie after reset: IF first, then alternation; each new grant lands in
    // the cycle of the previous response.
    step();
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h100;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      wait_grant(who, cyc);
      check("tie_owner", 32'(who), 32'(k % 2));
      if (k > 0) check("tie_gap", 32'(cyc), 32'd3);
      step();
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    drain();

    // Fetch with a zero-wait memory: rvalid at N+3.
    if_req  = 1'b1;
    if_addr = 32'h4;
    @(negedge clk);
    check("f_gnt", 32'(if_gnt), 32'd1);
    step();
    if_req  = 1'b0;
    if_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    check("f_mem_req",   32'(mem_req),   32'd1);
    check("f_mem_addr",  mem_addr,       32'h4);
    check("f_mem_wstrb", 32'({mem_we, mem_wstrb}), 32'd0);
    step();
    @(negedge clk);
    check("f_rvalid_n2", 32'(if_rvalid), 32'd0);
    step();
    @(negedge clk);
    check("f_rvalid_n3", 32'(if_rvalid), 32'd1);
    check("f_rdata_n3",  if_rdata,       32'h0050_0113);
    step();
    check("f_sb_empty", 32'(sb.size()), 32'd0);

    // Store with mem_ready low for 3 of the 4 ISSUE cycles.
    mem_ready = 1'b0;
    ls_req    = 1'b1;
    ls_we     = 1'b1;
    ls_addr   = 32'h20;
    ls_wdata  = 32'h2A;
    ls_wstrb  = 4'hF;
    @(negedge clk);
    check("s_gnt", 32'({if_gnt, ls_gnt}), 32'd1);
    step();
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    ls_wstrb = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1'b1;
      @(negedge clk);
      check("s_mem_req",   32'({mem_req, mem_we}), 32'd3);
      check("s_mem_addr",  mem_addr,       32'h20);
      check("s_mem_wdata", mem_wdata,      32'h2A);
      check("s_mem_wstrb", 32'(mem_wstrb), 32'hF);
      step();
    end
    @(negedge clk);
    check("s_rvalid", 32'(ls_rvalid), 32'd1);
    check("s_rdata",  ls_rdata,       32'd0);
    step();

    // Read timeout: rvalid exactly TO cycles after entering RESP.
    check("t_err_before", 32'(err), 32'd0);
    resp_en = 1'b0;
    ls_req  = 1'b1;
    ls_addr = 32'h40;
    @(negedge clk);
    check("t_gnt", 32'(ls_gnt), 32'd1);
    step();
    ls_req = 1'b0;
    step();
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk);
      if (k == int'(TO) - 1) check("t_rvalid_early", 32'(ls_rvalid), 32'd0);
      step();
    end
    @(negedge clk);
    check("t_rvalid", 32'(ls_rvalid), 32'd1);
    check("t_rdata",  ls_rdata,       ERR_WORD);
    check("t_err",    32'(err),       32'd1);
    step();
    resp_en = 1'b1;
    repeat (3) step();
    check("t_err_sticky", 32'(err), 32'd1);
    if_req  = 1'b1;
    if_addr = 32'h8;
    wait_grant(who, cyc);
    check("t_fetch_owner", 32'(who), 32'd0);
    step();
    if_req = 1'b0;
    drain();
    check("t_err_after_fetch", 32'(err), 32'd1);

    // Asynchronous reset while a store is stuck in ISSUE.
    mem_ready = 1'b0;
    ls_req    = 1'b1;
    ls_we     = 1'b1;
    ls_addr   = 32'h60;
    ls_wdata  = 32'h77;
    ls_wstrb  = 4'h3;
    @(negedge clk);
    step();
    ls_req = 1'b0;
    ls_we  = 1'b0;
    @(negedge clk);
    check("r_issue_req", 32'(mem_req), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("r_issue_req_drop",  32'({mem_req, mem_we, busy}), 32'd0);
    check("r_issue_addr_drop", mem_addr, 32'd0);
    check("r_issue_err_drop",  32'(err), 32'd0);
    sb.delete();
    step();
    rst       = 1'b1;
    mem_ready = 1'b1;
    step();

    // Asynchronous reset in RESP, then a late response after release.
    resp_en = 1'b0;
    ls_req  = 1'b1;
    ls_addr = 32'h50;
    @(negedge clk);
    check("r_gnt", 32'(ls_gnt), 32'd1);
    step();
    ls_req = 1'b0;
    step();
    #1;
    check("r_resp_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("r_resp_drop", 32'({mem_req, busy}), 32'd0);
    sb.delete();
    step();
    rst        = 1'b1;
    rvc        = rv_count;
    stray      = 1'b1;
    stray_data = 32'h1234_5678;
    step();
    stray = 1'b0;
    repeat (4) step();
    check("r_no_rvalid", 32'(rv_count), 32'(rvc));
    resp_en = 1'b1;

    // Stray response in IDLE, then a normal fetch.
    rvc        = rv_count;
    stray      = 1'b1;
    stray_data = 32'hCAFE_0001;
    step();
    stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("x_busy", 32'(busy), 32'd0);
      step();
    end
    check("x_no_rvalid", 32'(rv_count), 32'(rvc));
    if_req  = 1'b1;
    if_addr = 32'hC;
    wait_grant(who, cyc);
    check("x_fetch_owner", 32'(who), 32'd0);
    step();
    if_req = 1'b0;
    drain();
    check("x_fetch_done", 32'(rv_count), 32'(rvc + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
